instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Front end of the RV32IM pipeline; produces the instruction, pc and pc4 consumed by the decode stage.
- Owns the fetch address, the instruction-memory read handshake, a one-entry skid buffer and the IF/ID pipeline register.
- Responds to hazard-unit stall/flush and to EX-stage branch/jump redirects.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low; one clock domain.
- stall  input  1  hold IF/ID; no new instruction is accepted.
- flush  input  1  replace IF/ID contents with a bubble.
- branch_taken  input  1  one-cycle redirect request from EX.
- branch_target  input  32  redirect address; bits [1:0] are forced to 0.
- imem_addr  output  32  instruction memory read address.
- imem_read  output  1  read request.
- imem_readdata  input  32  read data, valid in the cycle where imem_read=1 and imem_busy=0.
- imem_busy  input  1  memory not ready; the current request must be held.
- instruction  output  32  IF/ID instruction.
- pc  output  32  IF/ID pc.
- pc4  output  32  IF/ID pc+4.
- valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset, asynchronous and active-low, forces:
  - state=FETCH, fetch_addr=RESET_PC, imem_read=0;
  - instruction=NOP_INSTR, pc=0, pc4=0, valid=0;
  - skid buffer empty.
- imem_read is 1 from the first clock edge after reset release.
- A fetch completes in a cycle where imem_read=1 and imem_busy=0. With no wait states, one instruction enters IF/ID per clock.
- Event priority: branch_taken > flush > stall.
- FETCH state (imem_read=1, imem_addr=fetch_addr):
  - Completion with branch_taken: discard the data; fetch_addr<=target; IF/ID<=bubble; stay in FETCH.
  - Completion with flush: discard the data; IF/ID<=bubble; fetch_addr unchanged, so the same address is refetched.
  - Completion with stall: capture {data, fetch_addr} into the skid buffer; IF/ID held; go to HOLD.
  - Completion, otherwise: IF/ID<={data, fetch_addr, fetch_addr+4, valid=1}; fetch_addr+=4.
  - Busy with branch_taken: redirect_addr<=target; IF/ID<=bubble; go to DRAIN.
  - Busy with flush: IF/ID<=bubble.
  - Busy with stall or no event: IF/ID held; the request is held stable.
- HOLD state (imem_read=0):
  - stall: remain in HOLD.
  - stall released: IF/ID<=buffer entry; fetch_addr<=buffered pc+4; go to FETCH.
  - branch_taken: drop the buffer; IF/ID<=bubble; fetch_addr<=target; go to FETCH.
  - flush: drop the buffer; IF/ID<=bubble; fetch_addr<=buffered pc so it is refetched; go to FETCH.
- DRAIN state (imem_read=1, imem_addr still the old address; an in-flight request is never aborted):
  - !busy: discard the data; fetch_addr<=redirect_addr; go to FETCH.
  - Another branch_taken while in DRAIN overwrites redirect_addr.
  - valid stays 0.
- Arithmetic: addresses are 32-bit, modulo 2^32. pc4 of 0xFFFF_FFFC is 0x0000_0000, with no flag.
- imem_addr and imem_read are registered or derived only from state and registers; they have no combinational path from stall, flush or branch.
- Reset asserted mid-transaction returns every output to its reset value immediately; the pending request is abandoned.

Decomposition:
- Shared package ifetch_pkg holds:
  - fetch state enumeration FETCH/HOLD/DRAIN;
  - NOP_INSTR constant;
  - default RESET_PC.
- Sub-module if_id_register holds the instruction/pc/pc4/valid register. Controls: load, bubble, hold.
- The FSM, fetch_addr, redirect_addr and skid buffer stay in instruction_fetch.

Test Plan:
- Reset release, imem returns addr-indexed words with busy=0 -> IF/ID shows pc 0x0,0x4,0x8 on consecutive cycles; pc4 = pc+4; valid=1 from cycle 2.
- busy=1 for 3 cycles at pc 0x8 -> imem_addr stays 0x8; IF/ID held; the word is loaded on the 4th cycle; next imem_addr=0xC.
- stall for 2 cycles coinciding with completion of 0x10 -> the word is buffered; imem_read=0; on release IF/ID pc=0x10; next fetch at 0x14.
- branch_taken target 0x103 while busy at 0x20 -> DRAIN holds addr 0x20 until !busy; the data is discarded; valid=0; next fetch at 0x100.
- flush during HOLD holding pc 0x30 -> IF/ID instruction=0x00000013, valid=0; refetch issued at 0x30.
- reset asserted while busy in DRAIN -> outputs return to reset values the same cycle; the first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// the bubble instruction and the default boot address.
package ifetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch targets are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read bus between the fetch stage (master) and the
// instruction memory (slave).
interface instruction_fetch_if;

    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_readdata;
    logic        imem_busy;

    modport master (
        output imem_addr,
        output imem_read,
        input  imem_readdata,
        input  imem_busy
    );

    modport slave (
        input  imem_addr,
        input  imem_read,
        output imem_readdata,
        output imem_busy
    );

endinterface

// File: rtl/instruction_fetch_if_id.sv
// IF/ID pipeline register; bubble overrides load, hold blocks a load.
module if_id_register #(
    parameter logic [31:0] NOP_INSTR = ifetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic        hold,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_pc4,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= NOP_INSTR;
            pc          <= 32'd0;
            pc4         <= 32'd0;
            valid       <= 1'b0;
        end else if (bubble) begin
            instruction <= NOP_INSTR;
            pc          <= 32'd0;
            pc4         <= 32'd0;
            valid       <= 1'b0;
        end else if (load && !hold) begin
            instruction <= load_instr;
            pc          <= load_pc;
            pc4         <= load_pc4;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: fetch address, imem handshake, one-entry skid buffer and
// redirect handling, feeding the IF/ID register.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = ifetch_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = ifetch_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_target,
    instruction_fetch_if.master        imem,
    output logic [31:0]                instruction,
    output logic [31:0]                pc,
    output logic [31:0]                pc4,
    output logic                       valid
);

    import ifetch_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_addr_q, fetch_addr_d;
    logic [31:0]  redirect_q, redirect_d;
    logic [31:0]  skid_instr_q, skid_pc_q;
    logic         read_en_q;
    logic         skid_load, from_skid;
    logic         ifid_load, ifid_bubble, ifid_hold;
    logic [31:0]  target;
    logic [31:0]  load_pc;

    assign target         = word_align(branch_target);
    assign imem.imem_addr = fetch_addr_q;
    assign imem.imem_read = read_en_q && (state_q != HOLD);
    assign load_pc        = from_skid ? skid_pc_q : fetch_addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FETCH;
            fetch_addr_q <= RESET_PC;
            redirect_q   <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
            read_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            redirect_q   <= redirect_d;
            read_en_q    <= 1'b1;
            if (skid_load) begin
                skid_instr_q <= imem.imem_readdata;
                skid_pc_q    <= fetch_addr_q;
            end
        end
    end

    // Redirects beat flushes beat stalls; an issued read is never abandoned.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        redirect_d   = redirect_q;
        skid_load    = 1'b0;
        from_skid    = 1'b0;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_hold    = 1'b1;
        case (state_q)
            FETCH: begin
                if (!read_en_q) begin
                    if (branch_taken) fetch_addr_d = target;
                    ifid_bubble = branch_taken || flush;
                end else if (!imem.imem_busy) begin
                    if (branch_taken) begin
                        fetch_addr_d = target;
                        ifid_bubble  = 1'b1;
                    end else if (flush) begin
                        ifid_bubble  = 1'b1;
                    end else if (stall) begin
                        skid_load    = 1'b1;
                        state_d      = HOLD;
                    end else begin
                        ifid_load    = 1'b1;
                        ifid_hold    = 1'b0;
                        fetch_addr_d = fetch_addr_q + 32'd4;
                    end
                end else if (branch_taken) begin
                    redirect_d  = target;
                    ifid_bubble = 1'b1;
                    state_d     = DRAIN;
                end else if (flush) begin
                    ifid_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    ifid_bubble  = 1'b1;
                    fetch_addr_d = target;
                    state_d      = FETCH;
                end else if (flush) begin
                    ifid_bubble  = 1'b1;
                    fetch_addr_d = skid_pc_q;
                    state_d      = FETCH;
                end else if (!stall) begin
                    ifid_load    = 1'b1;
                    ifid_hold    = 1'b0;
                    from_skid    = 1'b1;
                    fetch_addr_d = skid_pc_q + 32'd4;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                if (branch_taken) redirect_d = target;
                ifid_bubble = branch_taken || flush;
                if (!imem.imem_busy) begin
                    fetch_addr_d = redirect_d;
                    state_d      = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk         (clk),
        .reset       (reset),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .hold        (ifid_hold),
        .load_instr  (from_skid ? skid_instr_q : imem.imem_readdata),
        .load_pc     (load_pc),
        .load_pc4    (load_pc + 32'd4),
        .instruction (instruction),
        .pc          (pc),
        .pc4         (pc4),
        .valid       (valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: an address-indexed memory
// model and a scoreboard of expected IF/ID contents.
module tb_instruction_fetch;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_entry_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        busy = 1'b0;
    logic [31:0] instruction, pc, pc4;
    logic        valid;

    int checks = 0;
    int failures = 0;
    ifid_entry_t expected_q[$];

    instruction_fetch_if bus ();

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {~addr[15:0], addr[15:0]};
    endfunction

    assign bus.imem_busy     = busy;
    assign bus.imem_readdata = busy ? 32'hDEAD_BEEF : mem_word(bus.imem_addr);

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (bus),
        .instruction   (instruction),
        .pc            (pc),
        .pc4           (pc4),
        .valid         (valid)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs at a falling edge, optionally push the entry
    // that the rising edge should load, then compare IF/ID at the next fall.
    task automatic apply_stimulus(input logic st, input logic fl, input logic br,
                                  input logic [31:0] tgt, input logic bz,
                                  input logic exp_load, input logic [31:0] exp_addr);
        ifid_entry_t e;
        stall = st;
        flush = fl;
        branch_taken = br;
        branch_target = tgt;
        busy = bz;
        if (exp_load) begin
            e.instr = mem_word(exp_addr);
            e.pc    = exp_addr;
            e.pc4   = exp_addr + 32'd4;
            expected_q.push_back(e);
        end
        @(negedge clk);
        if (expected_q.size() > 0) begin
            e = expected_q.pop_front();
            check_output("ifid_instr", instruction, e.instr);
            check_output("ifid_pc", pc, e.pc);
            check_output("ifid_pc4", pc4, e.pc4);
            check_output("ifid_valid", {31'd0, valid}, 32'd1);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_read"}, {31'd0, bus.imem_read}, 32'd0);
        check_output({tag, "_addr"}, bus.imem_addr, 32'd0);
        check_output({tag, "_instr"}, instruction, NOP);
        check_output({tag, "_pc"}, pc, 32'd0);
        check_output({tag, "_pc4"}, pc4, 32'd0);
        check_output({tag, "_valid"}, {31'd0, valid}, 32'd0);
    endtask

    task automatic idle_step(input logic exp_load, input logic [31:0] addr);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, exp_load, addr);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clk);
        check_output("first_read", {31'd0, bus.imem_read}, 32'd1);
        check_output("first_addr", bus.imem_addr, 32'h0);
        check_output("first_valid", {31'd0, valid}, 32'd0);

        // Streaming with no wait states
        for (int a = 0; a < 8; a += 4) idle_step(1'b1, 32'(a));
        check_output("busy_addr0", bus.imem_addr, 32'h8);

        // Wait states at 0x8
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
            check_output("busy_addr", bus.imem_addr, 32'h8);
            check_output("busy_held_pc", pc, 32'h4);
        end
        idle_step(1'b1, 32'h8);
        check_output("after_busy_addr", bus.imem_addr, 32'hC);
        idle_step(1'b1, 32'hC);

        // Stall coinciding with completion of 0x10
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_output("hold_read", {31'd0, bus.imem_read}, 32'd0);
        check_output("hold_pc", pc, 32'hC);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_output("hold_read2", {31'd0, bus.imem_read}, 32'd0);
        idle_step(1'b1, 32'h10);
        check_output("release_read", {31'd0, bus.imem_read}, 32'd1);
        check_output("release_addr", bus.imem_addr, 32'h14);
        for (int a = 32'h14; a < 32'h20; a += 4) idle_step(1'b1, 32'(a));

        // Redirect while busy at 0x20 drains the outstanding read
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 32'd0);
        check_output("drain_valid", {31'd0, valid}, 32'd0);
        check_output("drain_instr", instruction, NOP);
        check_output("drain_addr", bus.imem_addr, 32'h20);
        check_output("drain_read", {31'd0, bus.imem_read}, 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        check_output("drain_addr2", bus.imem_addr, 32'h20);
        idle_step(1'b0, 32'd0);
        check_output("redirect_valid", {31'd0, valid}, 32'd0);
        check_output("redirect_addr", bus.imem_addr, 32'h100);
        idle_step(1'b1, 32'h100);

        // Flush while HOLD holds pc 0x30
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 32'd0);
        check_output("branch_valid", {31'd0, valid}, 32'd0);
        check_output("branch_addr", bus.imem_addr, 32'h30);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_output("hold30_read", {31'd0, bus.imem_read}, 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_output("flush_instr", instruction, NOP);
        check_output("flush_valid", {31'd0, valid}, 32'd0);
        check_output("refetch_read", {31'd0, bus.imem_read}, 32'd1);
        check_output("refetch_addr", bus.imem_addr, 32'h30);
        idle_step(1'b1, 32'h30);

        // Unaligned target and pc4 wrap-around at the top of memory
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        check_output("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        idle_step(1'b1, 32'hFFFF_FFFC);
        check_output("wrapped_addr", bus.imem_addr, 32'h0);
        idle_step(1'b1, 32'h0);

        // A second redirect in DRAIN replaces the first
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'd0);
        idle_step(1'b0, 32'd0);
        check_output("overwrite_addr", bus.imem_addr, 32'h300);

        // Reset asserted while busy in DRAIN
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 32'd0);
        branch_taken = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        busy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("restart_addr", bus.imem_addr, 32'h0);
        check_output("restart_read", {31'd0, bus.imem_read}, 32'd1);
        idle_step(1'b1, 32'h0);
        idle_step(1'b1, 32'h4);

        check_output("scoreboard_empty", 32'(expected_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
